// File: rtl/awg_playback_sequencer.sv
// Paces AWG samples from the unpacker out to the DAC at a programmable period, gated by trigger mode.
// Latches and counts underflows, which occur when a sample is due but the unpacker has none ready.
module awg_playback_sequencer #(
   parameter int unsigned       BW_OUT            = 8,
   parameter int unsigned       DIV_W             = 16,
   parameter int unsigned       UFC_W             = 16,
   parameter logic [BW_OUT-1:0] IDLE_VAL          = '0,
   parameter logic [6:0]        TRIGGER_MODE_NONE = 7'h01,
   parameter logic [6:0]        TRIGGER_MODE_EDGE = 7'h02,
   parameter logic [6:0]        RESET_EDGE        = 7'h04
) (
   input  logic              clk100,
   input  logic              rst_n,
   input  logic [6:0]        trigger_mode,
   input  logic              trig_in,
   input  logic [DIV_W-1:0]  period,
   input  logic              awg_valid,
   output logic              awg_ready,
   input  logic [BW_OUT-1:0] awg_out,
   output logic [BW_OUT-1:0] dac_out,
   output logic              dac_strobe,
   output logic              running,
   output logic              underflow,
   output logic [UFC_W-1:0]  underflow_cnt,
   input  logic              clr_err
);

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      RUNNING
   } state_t;

   state_t           state;
   logic [DIV_W-1:0] cnt;
   logic [1:0]       trig_sync;
   logic             trig_prev;
   logic             trig_rise;
   logic [6:0]       mode_prev;

   logic mode_none;
   logic mode_valid;
   logic mode_changed;
   logic tick;
   logic xfer;
   logic ufl_evt;

   assign mode_none    = (trigger_mode == TRIGGER_MODE_NONE);
   assign mode_valid   = mode_none || (trigger_mode == TRIGGER_MODE_EDGE) ||
                         (trigger_mode == RESET_EDGE);
   assign mode_changed = (trigger_mode != mode_prev);

   assign tick      = (state == RUNNING) && (cnt == '0);
   assign awg_ready = tick;
   assign running   = (state == RUNNING);
   assign xfer      = tick && awg_valid;
   assign ufl_evt   = tick && !awg_valid;

   // trig_in is asynchronous: two flops resolve metastability, the third is used for edge detection.
   // The rise is registered so that it is a clean one-cycle pulse.
   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         trig_sync <= '0;
         trig_prev <= 1'b0;
         trig_rise <= 1'b0;
         mode_prev <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         trig_sync <= {trig_sync[0], trig_in};
         trig_prev <= trig_sync[1];
         trig_rise <= trig_sync[1] & ~trig_prev;
         mode_prev <= trigger_mode;
      end
   end

   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mode_valid) state <= ARMED;
            end
            ARMED: begin
               if (mode_changed) begin
                  state <= IDLE;
               end else if (mode_none || trig_rise) begin
                  state <= RUNNING;
                  cnt   <= '0;
               end
            end
            RUNNING: begin
               // A mode change beats a simultaneous rise and abandons the current period.
               if (mode_changed) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if ((trigger_mode == RESET_EDGE) && trig_rise) begin
                  cnt <= '0;
               end else if (tick) begin
                  cnt <= period;
               end else begin
                  cnt <= cnt - DIV_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A handshake that completes on the same edge as a mode change is still honoured.
   // The unpacker has already released that sample.
   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         dac_out       <= IDLE_VAL;
         dac_strobe    <= 1'b0;
         underflow     <= 1'b0;
         underflow_cnt <= '0;
      end else begin
         dac_strobe <= xfer;
         if (xfer) dac_out <= awg_out;

         if (clr_err) begin
            underflow     <= 1'b0;
            underflow_cnt <= '0;
         end else if (ufl_evt) begin
            underflow <= 1'b1;
            if (underflow_cnt != '1) underflow_cnt <= underflow_cnt + UFC_W'(1);
         end
      end
   end

endmodule
